score_ram_writer: RTL

Write-side companion to the HUD score text RAM. On request, it captures the game's binary score and lives count. It converts the score to decimal with a serial double-dabble and writes the ASCII digits into the fixed text-RAM slots, one byte per cycle, using the RAM's write port (write_address / data_In / we). The game-logic FSM drives it; the text RAM's read port stays with the HUD renderer.

---
 rtl/hud_text_pkg.sv | 18 +
 rtl/bin2bcd_serial.sv | 51 +++++
 rtl/score_ram_writer.sv | 108 ++++++++++
 3 files changed

// File: rtl/hud_text_pkg.sv
// Shared constants and types for the HUD text RAM write side.
// Slot addresses are fixed by the label layout baked into the RAM image.
package hud_text_pkg;

  localparam logic [7:0] SCORE_BASE_ADDR = 8'd7;
  localparam logic [7:0] LIVES_ADDR      = 8'd32;
  localparam logic [7:0] ASCII_ZERO      = 8'h30;
  localparam int         HUD_RAM_DEPTH   = 160;

  typedef enum logic [2:0] {
    IDLE,
    CONVERT,
    WRITE_SCORE,
    WRITE_LIVES,
    FINISH
  } writer_state_t;

endpackage

// File: rtl/bin2bcd_serial.sv
// Serial double-dabble: one shift-add-3 step per cycle, WIDTH cycles per conversion.
// done is combinational and marks the cycle whose closing edge performs the last shift.
module bin2bcd_serial #(
  parameter int WIDTH  = 14,
  parameter int DIGITS = 4
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin_in,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] shift_r;
  logic [CNT_W-1:0] cnt;
  logic             running;

  function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    r = b;
    for (int i = 0; i < DIGITS; i++) begin
      if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  assign done = running && (cnt == '0);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      shift_r <= '0;
      bcd     <= '0;
      cnt     <= '0;
      running <= 1'b0;
    end else if (start) begin
      shift_r <= bin_in;
      bcd     <= '0;
      cnt     <= CNT_W'(WIDTH - 1);
      running <= 1'b1;
    end else if (running) begin
      {bcd, shift_r} <= {add3(bcd), shift_r} << 1;
      if (cnt == '0) running <= 1'b0;
      else           cnt     <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/score_ram_writer.sv
// Refreshes the score and lives digits in the HUD text RAM on request.
// Requests arriving mid-refresh coalesce into a single follow-up pass.
module score_ram_writer
  import hud_text_pkg::*;
#(
  parameter int SCORE_W    = 14,
  parameter int NUM_DIGITS = 4
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               update_req,
  input  logic [SCORE_W-1:0] score,
  input  logic [3:0]         lives,
  output logic [7:0]         write_address,
  output logic [7:0]         data_In,
  output logic               we,
  output logic               busy,
  output logic               done
);

  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [SCORE_W-1:0] MAX_SCORE = SCORE_W'(10**NUM_DIGITS - 1);

  writer_state_t      state;
  logic               pending;
  logic [3:0]         lives_r;
  logic [IDX_W-1:0]   idx;
  logic               accept;
  logic [SCORE_W-1:0] score_sat;
  logic               conv_done;
  logic [BCD_W-1:0]   bcd;

  function automatic logic [3:0] digit_at(input logic [BCD_W-1:0] b,
                                          input logic [IDX_W-1:0] k);
    return b[4*(NUM_DIGITS - 1 - int'(k)) +: 4];
  endfunction

  assign accept    = (state == IDLE) && (update_req || pending);
  assign score_sat = (score > MAX_SCORE) ? MAX_SCORE : score;

  // The converter latches the saturated score on the same edge the FSM accepts
  bin2bcd_serial #(
    .WIDTH  (SCORE_W),
    .DIGITS (NUM_DIGITS)
  ) u_conv (
    .Clk    (Clk),
    .Reset  (Reset),
    .start  (accept),
    .bin_in (score_sat),
    .done   (conv_done),
    .bcd    (bcd)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state         <= IDLE;
      pending       <= 1'b0;
      lives_r       <= '0;
      idx           <= '0;
      write_address <= '0;
      data_In       <= '0;
      we            <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      we   <= 1'b0;
      done <= 1'b0;
      if (state != IDLE && update_req) pending <= 1'b1;
      case (state)
        IDLE: begin
          if (update_req || pending) begin
            lives_r <= (lives > 4'd9) ? 4'd9 : lives;
            pending <= 1'b0;
            busy    <= 1'b1;
            state   <= CONVERT;
          end
        end
        CONVERT: begin
          if (conv_done) begin
            idx   <= '0;
            state <= WRITE_SCORE;
          end
        end
        WRITE_SCORE: begin
          we            <= 1'b1;
          write_address <= SCORE_BASE_ADDR + 8'(idx);
          data_In       <= ASCII_ZERO + {4'h0, digit_at(bcd, idx)};
          if (idx == IDX_W'(NUM_DIGITS - 1)) state <= WRITE_LIVES;
          else                               idx   <= idx + 1'b1;
        end
        WRITE_LIVES: begin
          we            <= 1'b1;
          write_address <= LIVES_ADDR;
          data_In       <= ASCII_ZERO + {4'h0, lives_r};
          state         <= FINISH;
        end
        FINISH: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
